fifo_wr_arbiter: RTL

Round-robin write arbiter that shares one synchronous 8-bit FIFO write port among NUM_REQ producers. Each producer presents data with a valid/ready handshake; the arbiter grants one producer at a time, drives the FIFO `wr`/`din` pins, and honours the FIFO `full` flag. It sits directly in front of the FIFO, on the same clock and reset.

---
 rtl/fifo_arb_pkg.sv | 17 +
 rtl/fifo_rr_pick.sv | 32 +++
 rtl/fifo_wr_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter.
// Burst grants are enabled by defining FIFO_ARB_BURST_EN.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  // Index width for a requester count; never narrower than one bit.
  localparam int MIN_IDX_W = 1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : MIN_IDX_W;
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin search: first set bit of valid at or above ptr,
// wrapping modulo NUM_REQ.
module fifo_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IW-1:0]      ptr,
  output logic               found,
  output logic [IW-1:0]      idx
);

  logic [IW:0] pos;

  // One extra bit on pos so ptr+k never overflows before the wrap.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(NUM_REQ)) pos = pos - (IW+1)'(NUM_REQ);
      if (!found && valid[pos[IW-1:0]]) begin
        found = 1'b1;
        idx   = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// FIFO_ARB_BURST_EN: grants last up to MAX_BURST beats; otherwise one beat.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wr,
  output logic [DATA_W-1:0]         fifo_din,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                      busy
);

  localparam int IW = idx_w(NUM_REQ);

  arb_state_t       state;
  logic [IW-1:0]    owner;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    next_rr;
  logic             pick_found;
  logic [IW-1:0]    pick_idx;
  logic             own_valid;
  logic [DATA_W-1:0] own_data;
  logic             last_beat;

`ifdef FIFO_ARB_BURST_EN
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [CW-1:0] beat_cnt;
  assign last_beat = (beat_cnt == CW'(MAX_BURST - 1));
`else
  assign last_beat = 1'b1;
`endif

  fifo_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign busy     = (state == ARB_BURST);
  assign grant_id = owner;
  assign next_rr  = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);

  // Handshake: a beat moves on a posedge where req_valid[i] and req_ready[i]
  // are both high; fifo_wr is exactly that condition for the owner.
  // Control depends only on state, req_valid and fifo_full, never on data.
  always_comb begin
    own_valid = req_valid[owner];
    own_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == IW'(i)) own_data = req_data[i*DATA_W +: DATA_W];
    end
    req_ready = '0;
    fifo_wr   = 1'b0;
    fifo_din  = '0;
    if (busy) begin
      req_ready[owner] = ~fifo_full;
      fifo_wr          = own_valid & ~fifo_full;
      fifo_din         = own_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ARB_IDLE;
      owner  <= '0;
      rr_ptr <= '0;
`ifdef FIFO_ARB_BURST_EN
      beat_cnt <= '0;
`endif
    end else begin
      case (state)
        ARB_IDLE: begin
          // A full FIFO does not hold off the grant; the burst simply stalls.
          if (pick_found) begin
            owner <= pick_idx;
            state <= ARB_BURST;
`ifdef FIFO_ARB_BURST_EN
            beat_cnt <= '0;
`endif
          end
        end
        ARB_BURST: begin
          if (!own_valid) begin
            state  <= ARB_IDLE;
            rr_ptr <= next_rr;
          end else if (fifo_wr) begin
            if (last_beat) begin
              state  <= ARB_IDLE;
              rr_ptr <= next_rr;
            end
`ifdef FIFO_ARB_BURST_EN
            beat_cnt <= beat_cnt + CW'(1);
`endif
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
